// File: rtl/booth_mult_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : booth_mult_arbiter_if                                            |
// | Purpose  : Bundles the client request/response bus and the shared Booth     |
// |            multiplier start/done bus used by booth_mult_arbiter.            |
// | Signals  : req/req_a/req_b      client requests and packed operands         |
// |            gnt                  one-hot operand-capture pulse               |
// |            rsp_valid/rsp_ready  one-hot response handshake                  |
// |            rsp_product/rsp_err  shared response payload                     |
// |            mul_a/mul_b          operands to the multiplier                  |
// |            mul_clr/mul_start    multiplier control pulses                   |
// |            mul_done/mul_product multiplier result                           |
// |            busy                 arbiter not idle                            |
// | Modports : master = arbiter side, slave = clients + multiplier side         |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface booth_mult_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [2*WIDTH-1:0]    rsp_product;
  logic                  rsp_err;
  logic [WIDTH-1:0]      mul_a;
  logic [WIDTH-1:0]      mul_b;
  logic                  mul_clr;
  logic                  mul_start;
  logic                  mul_done;
  logic [2*WIDTH-1:0]    mul_product;
  logic                  busy;

  modport master (
    input  req, req_a, req_b, rsp_ready, mul_done, mul_product,
    output gnt, rsp_valid, rsp_product, rsp_err, mul_a, mul_b,
           mul_clr, mul_start, busy
  );

  modport slave (
    output req, req_a, req_b, rsp_ready, mul_done, mul_product,
    input  gnt, rsp_valid, rsp_product, rsp_err, mul_a, mul_b,
           mul_clr, mul_start, busy
  );
endinterface
`default_nettype wire

// File: rtl/booth_mult_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : booth_mult_arbiter                                               |
// | Purpose  : Shares one sequential Booth multiplier between NREQ clients.     |
// |            Round-robin arbitration, operand capture, clear/start of the     |
// |            multiplier, watchdog-guarded wait for done, and return of the    |
// |            product over a per-client valid/ready handshake.                 |
// | Ports    : clk    - clock, rising edge                                      |
// |            rst_n  - asynchronous active-low reset                           |
// |            bus    - booth_mult_arbiter_if.master (client + multiplier bus)  |
// | Params   : NREQ (2..8), WIDTH (operand bits), TIMEOUT (watchdog cycles)     |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module booth_mult_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 40
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  booth_mult_arbiter_if.master bus
);

  localparam int          PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW:0] c_NREQ    = (PW+1)'(NREQ);
  localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT);

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_LOAD  = 3'd1;
  localparam logic [2:0] c_ST_START = 3'd2;
  localparam logic [2:0] c_ST_WAIT  = 3'd3;
  localparam logic [2:0] c_ST_RESP  = 3'd4;

  logic [2:0]         r_state;
  logic [PW-1:0]      r_ptr;
  logic [PW-1:0]      r_owner;
  logic [15:0]        r_wdog;
  logic [NREQ-1:0]    r_gnt;
  logic [NREQ-1:0]    r_rsp_valid;
  logic [2*WIDTH-1:0] r_rsp_product;
  logic               r_rsp_err;
  logic [WIDTH-1:0]   r_mul_a;
  logic [WIDTH-1:0]   r_mul_b;
  logic               r_mul_clr;
  logic               r_mul_start;
  logic               r_busy;

  // Per-client operand views of the packed request buses.
  logic [WIDTH-1:0] w_a [NREQ];
  logic [WIDTH-1:0] w_b [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_a[gi] = bus.req_a[gi*WIDTH +: WIDTH];
      assign w_b[gi] = bus.req_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Round-robin pick: first asserted request scanning from r_ptr upward,
  // wrapping modulo NREQ (which need not be a power of two).
  logic [PW:0]   w_idx;
  logic [PW-1:0] w_winner;
  logic          w_found;

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_idx >= c_NREQ) begin
        w_idx = w_idx - c_NREQ;
      end
      if (!w_found && bus.req[w_idx[PW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[PW-1:0];
      end
    end
  end

  // Owner becomes lowest priority once its response completes.
  logic [PW:0]     w_owner_inc;
  logic [PW-1:0]   w_next_ptr;
  logic [NREQ-1:0] w_winner_oh;
  logic [NREQ-1:0] w_owner_oh;

  always_comb begin
    w_owner_inc = {1'b0, r_owner} + (PW+1)'(1);
    w_next_ptr  = (w_owner_inc == c_NREQ) ? '0 : w_owner_inc[PW-1:0];
    w_winner_oh = {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
    w_owner_oh  = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= c_ST_IDLE;
      r_ptr         <= '0;
      r_owner       <= '0;
      r_wdog        <= '0;
      r_gnt         <= '0;
      r_rsp_valid   <= '0;
      r_rsp_product <= '0;
      r_rsp_err     <= 1'b0;
      r_mul_a       <= '0;
      r_mul_b       <= '0;
      r_mul_clr     <= 1'b0;
      r_mul_start   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      // gnt, mul_clr and mul_start are single-cycle pulses.
      r_gnt       <= '0;
      r_mul_clr   <= 1'b0;
      r_mul_start <= 1'b0;

      case (r_state)
        c_ST_IDLE: begin
          if (w_found) begin
            r_owner   <= w_winner;
            r_mul_a   <= w_a[w_winner];
            r_mul_b   <= w_b[w_winner];
            r_gnt     <= w_winner_oh;
            r_mul_clr <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= c_ST_LOAD;
          end
        end

        c_ST_LOAD: begin
          r_mul_start <= 1'b1;
          r_state     <= c_ST_START;
        end

        c_ST_START: begin
          r_wdog  <= c_TIMEOUT;
          r_state <= c_ST_WAIT;
        end

        c_ST_WAIT: begin
          // Done is checked before the watchdog so a late done still wins.
          if (bus.mul_done) begin
            r_rsp_product <= bus.mul_product;
            r_rsp_err     <= 1'b0;
            r_rsp_valid   <= w_owner_oh;
            r_state       <= c_ST_RESP;
          end else if (r_wdog <= 16'd1) begin
            r_wdog        <= '0;
            r_rsp_product <= '0;
            r_rsp_err     <= 1'b1;
            r_rsp_valid   <= w_owner_oh;
            r_state       <= c_ST_RESP;
          end else begin
            r_wdog <= r_wdog - 16'd1;
          end
        end

        c_ST_RESP: begin
          if (bus.rsp_ready[r_owner]) begin
            r_rsp_valid <= '0;
            r_ptr       <= w_next_ptr;
            r_busy      <= 1'b0;
            r_state     <= c_ST_IDLE;
          end
        end

        default: begin
          r_rsp_valid <= '0;
          r_busy      <= 1'b0;
          r_state     <= c_ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt         = r_gnt;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_product = r_rsp_product;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.mul_a       = r_mul_a;
  assign bus.mul_b       = r_mul_b;
  assign bus.mul_clr     = r_mul_clr;
  assign bus.mul_start   = r_mul_start;
  assign bus.busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_booth_mult_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_booth_mult_arbiter                                            |
// | Purpose  : Directed bench for booth_mult_arbiter. Stimulus pushes expected  |
// |            grants and responses into queues; a monitor pops and compares    |
// |            whenever the DUT pulses gnt or raises rsp_valid.                 |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_booth_mult_arbiter;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  booth_mult_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  booth_mult_arbiter #(
    .NREQ   (NREQ),
    .WIDTH  (WIDTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_gnt    = 0;

  typedef struct packed {
    logic [7:0]  owner;
    logic [15:0] prod;
    logic        err;
  } rsp_t;

  int   gnt_q[$];
  rsp_t rsp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name, input int waited);
    n_checks++;
    n_errors++;
    $display("FAIL %s: condition not reached after %0d cycles", name, waited);
  endtask

  function automatic rsp_t mk_rsp(input int owner, input logic [15:0] prod, input logic err);
    rsp_t r;
    r.owner = 8'(owner);
    r.prod  = prod;
    r.err   = err;
    return r;
  endfunction

  // ---------------------------------------------------------------- multiplier model
  // Auto mode: done rises mdl_delay cycles after start with the signed product
  // of mul_a/mul_b and stays high until the next mul_clr. Manual mode: the
  // stimulus drives done/product directly.
  bit          mdl_auto  = 1'b1;
  int          mdl_delay = 4;
  logic        man_done  = 1'b0;
  logic [15:0] man_prod  = 16'h0;
  logic        auto_done = 1'b0;
  logic [15:0] auto_prod = 16'h0;
  int          auto_cnt  = 0;
  bit          auto_pend = 1'b0;

  assign bus.mul_done    = mdl_auto ? auto_done : man_done;
  assign bus.mul_product = mdl_auto ? auto_prod : man_prod;

  initial begin
    logic signed [15:0] ma;
    logic signed [15:0] mb;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        auto_done = 1'b0;
        auto_pend = 1'b0;
      end else begin
        if (bus.mul_clr) auto_done = 1'b0;
        if (bus.mul_start) begin
          auto_cnt  = mdl_delay;
          auto_pend = 1'b1;
        end else if (auto_pend) begin
          auto_cnt--;
          if (auto_cnt == 0) begin
            ma        = 16'($signed(bus.mul_a));
            mb        = 16'($signed(bus.mul_b));
            auto_prod = 16'(ma * mb);
            auto_done = 1'b1;
            auto_pend = 1'b0;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- monitor
  logic prev_valid = 1'b0;

  initial begin
    int   eg;
    rsp_t er;
    forever begin
      @(posedge clk);
      #1;
      if (bus.gnt != '0) begin
        n_gnt++;
        if (gnt_q.size() == 0) begin
          check("gnt_unexpected", 32'(bus.gnt), 32'h0);
        end else begin
          eg = gnt_q.pop_front();
          check("gnt_order", 32'(bus.gnt), 32'(1) << eg);
        end
      end
      if (bus.rsp_valid != '0 && !prev_valid) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", 32'(bus.rsp_valid), 32'h0);
        end else begin
          er = rsp_q.pop_front();
          check("rsp_owner",   32'(bus.rsp_valid),   32'(1) << er.owner);
          check("rsp_product", 32'(bus.rsp_product), 32'(er.prod));
          check("rsp_err",     32'(bus.rsp_err),     32'(er.err));
        end
      end
      prev_valid = |bus.rsp_valid;
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    bus.req_a[i*WIDTH +: WIDTH] = a;
    bus.req_b[i*WIDTH +: WIDTH] = b;
  endtask

  // Called at posedge+1; returns the number of cycles advanced until rsp_valid.
  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (bus.rsp_valid == '0 && n < max) begin
      tick(1);
      n++;
    end
    if (bus.rsp_valid == '0) bound_fail("wait_rsp_valid", n);
  endtask

  task automatic wait_quiet(input int max);
    int n;
    n = 0;
    while ((bus.busy || gnt_q.size() != 0 || rsp_q.size() != 0) && n < max) begin
      tick(1);
      n++;
    end
    if (bus.busy || gnt_q.size() != 0 || rsp_q.size() != 0) bound_fail("wait_quiet", n);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},       32'(bus.gnt),         32'h0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid),   32'h0);
    check({tag, "_rsp_prod"},  32'(bus.rsp_product), 32'h0);
    check({tag, "_rsp_err"},   32'(bus.rsp_err),     32'h0);
    check({tag, "_mul_a"},     32'(bus.mul_a),       32'h0);
    check({tag, "_mul_b"},     32'(bus.mul_b),       32'h0);
    check({tag, "_mul_clr"},   32'(bus.mul_clr),     32'h0);
    check({tag, "_mul_start"}, 32'(bus.mul_start),   32'h0);
    check({tag, "_busy"},      32'(bus.busy),        32'h0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int n;
    int g0;
    bus.req       = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    check("reset_idle_busy", 32'(bus.busy), 32'h0);

    // Contention: req=1011 held, order 0,1,3,0,1,3
    @(negedge clk);
    set_ops(0, 8'h05, 8'h03);
    set_ops(1, 8'hFF, 8'h7F);
    set_ops(2, 8'h11, 8'h11);
    set_ops(3, 8'h10, 8'hF0);
    mdl_delay     = 5;
    bus.rsp_ready = 4'b1111;
    for (int r = 0; r < 2; r++) begin
      gnt_q.push_back(0); rsp_q.push_back(mk_rsp(0, 16'h000F, 1'b0));
      gnt_q.push_back(1); rsp_q.push_back(mk_rsp(1, 16'hFF81, 1'b0));
      gnt_q.push_back(3); rsp_q.push_back(mk_rsp(3, 16'hFF00, 1'b0));
    end
    g0      = n_gnt;
    bus.req = 4'b1011;
    n = 0;
    while (n_gnt - g0 < 6 && n < 200) begin
      tick(1);
      n++;
    end
    if (n_gnt - g0 < 6) bound_fail("contention_grants", n);
    @(negedge clk);
    bus.req = '0;
    wait_quiet(100);

    // Single request: 0x07 * 0xFD = -21
    @(negedge clk);
    set_ops(0, 8'h07, 8'hFD);
    mdl_delay     = 4;
    bus.rsp_ready = 4'b0001;
    gnt_q.push_back(0);
    rsp_q.push_back(mk_rsp(0, 16'hFFEB, 1'b0));
    bus.req = 4'b0001;
    tick(1);                                   // cycle 1
    check("single_gnt",   32'(bus.gnt),     32'h1);
    check("single_clr",   32'(bus.mul_clr), 32'h1);
    check("single_busy",  32'(bus.busy),    32'h1);
    check("single_mul_a", 32'(bus.mul_a),   32'h07);
    check("single_mul_b", 32'(bus.mul_b),   32'hFD);
    @(negedge clk);
    bus.req = '0;
    tick(1);                                   // cycle 2
    check("single_start",    32'(bus.mul_start), 32'h1);
    check("single_gnt_drop", 32'(bus.gnt),       32'h0);
    wait_valid(20, n);
    check("single_latency", 32'(n), 32'd5);    // response in cycle 7
    wait_quiet(20);

    // Backpressure on index 2: -128 * -128 = 16384
    @(negedge clk);
    set_ops(2, 8'h80, 8'h80);
    mdl_delay     = 3;
    bus.rsp_ready = 4'b1011;
    gnt_q.push_back(2);
    rsp_q.push_back(mk_rsp(2, 16'h4000, 1'b0));
    bus.req = 4'b0100;
    tick(1);
    check("bp_gnt", 32'(bus.gnt), 32'h4);
    @(negedge clk);
    bus.req = '0;
    tick(1);
    wait_valid(20, n);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("bp_valid_hold", 32'(bus.rsp_valid),   32'h4);
      check("bp_prod_hold",  32'(bus.rsp_product), 32'h4000);
      check("bp_busy_hold",  32'(bus.busy),        32'h1);
    end
    @(negedge clk);
    bus.rsp_ready = 4'b0100;
    tick(1);
    check("bp_valid_drop", 32'(bus.rsp_valid), 32'h0);
    check("bp_busy_drop",  32'(bus.busy),      32'h0);

    // Timeout: done never arrives, response 40 cycles after WAIT entry
    @(negedge clk);
    mdl_auto      = 1'b0;
    man_done      = 1'b0;
    man_prod      = 16'hDEAD;
    set_ops(1, 8'h03, 8'h04);
    bus.rsp_ready = 4'b0010;
    gnt_q.push_back(1);
    rsp_q.push_back(mk_rsp(1, 16'h0000, 1'b1));
    bus.req = 4'b0010;
    tick(1);                                   // cycle 1
    @(negedge clk);
    bus.req = '0;
    wait_valid(60, n);
    check("timeout_latency", 32'(n), 32'd42);  // cycle 43
    wait_quiet(20);

    // Done on the expiry cycle wins
    @(negedge clk);
    set_ops(1, 8'h02, 8'h03);
    man_prod = 16'h0006;
    gnt_q.push_back(1);
    rsp_q.push_back(mk_rsp(1, 16'h0006, 1'b0));
    bus.req = 4'b0010;
    tick(1);                                   // cycle 1
    @(negedge clk);
    bus.req = '0;
    tick(41);                                  // cycle 42
    check("expiry_not_yet", 32'(bus.rsp_valid), 32'h0);
    @(negedge clk);
    man_done = 1'b1;
    tick(1);                                   // cycle 43
    check("expiry_valid", 32'(bus.rsp_valid), 32'h2);
    @(negedge clk);
    man_done = 1'b0;
    wait_quiet(20);

    // Stale done held before the request
    @(negedge clk);
    man_done      = 1'b1;
    man_prod      = 16'h1234;
    set_ops(0, 8'h21, 8'h43);
    bus.rsp_ready = 4'b0001;
    gnt_q.push_back(0);
    rsp_q.push_back(mk_rsp(0, 16'h0BAD, 1'b0));
    bus.req = 4'b0001;
    tick(1);                                   // cycle 1
    @(negedge clk);
    bus.req = '0;
    tick(2);                                   // cycle 3
    @(negedge clk);
    man_done = 1'b0;
    tick(5);                                   // cycle 8
    check("stale_no_valid", 32'(bus.rsp_valid), 32'h0);
    @(negedge clk);
    man_done = 1'b1;
    man_prod = 16'h0BAD;
    tick(1);                                   // cycle 9
    check("stale_valid", 32'(bus.rsp_valid), 32'h1);
    @(negedge clk);
    man_done = 1'b0;
    wait_quiet(20);

    // Reset mid-WAIT, then ptr restarts at 0
    @(negedge clk);
    set_ops(3, 8'h0A, 8'h0B);
    bus.rsp_ready = '0;
    gnt_q.push_back(3);
    bus.req = 4'b1000;
    tick(1);                                   // cycle 1
    @(negedge clk);
    bus.req = '0;
    tick(4);                                   // cycle 5, WAIT
    check("rstw_busy_before", 32'(bus.busy),  32'h1);
    check("rstw_mul_a_before", 32'(bus.mul_a), 32'h0A);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rstw");
    repeat (2) @(negedge clk);
    rst_n         = 1'b1;
    mdl_auto      = 1'b1;
    mdl_delay     = 2;
    set_ops(1, 8'h09, 8'h09);
    set_ops(2, 8'h05, 8'h05);
    bus.rsp_ready = 4'b0110;
    gnt_q.push_back(1);
    rsp_q.push_back(mk_rsp(1, 16'h0051, 1'b0));
    bus.req = 4'b0110;
    tick(1);
    check("rstw_first_gnt", 32'(bus.gnt), 32'h2);
    @(negedge clk);
    bus.req = '0;
    wait_quiet(30);

    check("sb_gnt_empty", 32'(gnt_q.size()), 32'h0);
    check("sb_rsp_empty", 32'(rsp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
